// File: rtl/int_seq_pkg.sv
// int_seq_pkg
//   Shared definitions for the interrupt/reset sequencer: sequencer state
//   encoding, vector low bytes, the fixed vector high byte and the BRK opcode
//   that is injected into the instruction register.
package int_seq_pkg;

    typedef enum logic [1:0] {
        RST_SEQ = 2'd0,
        IDLE    = 2'd1,
        NMI_SEQ = 2'd2,
        IRQ_SEQ = 2'd3
    } seq_state_t;

    localparam logic [7:0] VEC_RST_LO = 8'hFC;
    localparam logic [7:0] VEC_NMI_LO = 8'hFA;
    localparam logic [7:0] VEC_IRQ_LO = 8'hFE;
    localparam logic [7:0] VEC_HI     = 8'hFF;
    localparam logic [7:0] OPC_BRK    = 8'h00;

    // IDLE shares the IRQ vector: a software BRK executed from IDLE
    // vectors through 0xFFFE just like a hardware IRQ.
    function automatic logic [7:0] vec_lo_for(input seq_state_t s);
        logic [7:0] v;
        v = VEC_IRQ_LO;
        case (s)
            RST_SEQ: v = VEC_RST_LO;
            NMI_SEQ: v = VEC_NMI_LO;
            default: v = VEC_IRQ_LO;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/int_seq_sync_ff.sv
// sync_ff
//   Two-flop synchronizer for an asynchronous, idle-high pin.
//   Ports:
//     clk   - sampling clock
//     rst_n - asynchronous active-low reset; both flops reset to 1
//     d     - asynchronous input pin
//     q     - synchronized output
module sync_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/int_seq.sv
// int_seq
//   Interrupt and reset sequencer in front of the CPU instruction register.
//   At each opcode fetch it either passes D_BUS through or injects BRK (0x00)
//   so that reset, NMI, IRQ and software BRK all run one microcode path.
//   Ports:
//     clk      - CPU clock
//     RST      - asynchronous active-low reset
//     NMI      - active-low, falling-edge NMI pin (asynchronous)
//     IRQ      - active-low, level IRQ pin (asynchronous)
//     SO       - active-low, falling-edge set-overflow pin (asynchronous)
//     sr_I     - interrupt-disable flag from the status register
//     fetch    - high in the cycle the CPU loads IR
//     vec_ack  - high in the cycle the CPU loads PCH from the vector
//     D_BUS    - external data bus
//     ir_out   - opcode to IR (D_BUS or 0x00)
//     int_take - high in the fetch cycle that injects 0x00
//     vec_lo   - vector low byte for the running sequence
//     seq_rst  - high while the reset sequence runs (stack writes suppressed)
//     brk_flag - B bit for the pushed status
//     so_set   - one-cycle pulse that sets V
module int_seq
    import int_seq_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic       NMI,
    input  logic       IRQ,
    input  logic       SO,
    input  logic       sr_I,
    input  logic       fetch,
    input  logic       vec_ack,
    input  logic [7:0] D_BUS,
    output logic [7:0] ir_out,
    output logic       int_take,
    output logic [7:0] vec_lo,
    output logic       seq_rst,
    output logic       brk_flag,
    output logic       so_set
);

    seq_state_t state;
    logic       nmi_s, irq_s, so_s;
    logic       nmi_d, so_d;
    logic       nmi_pend;
    logic       nmi_fall;
    logic       irq_req;
    logic       take_req;

    sync_ff u_sync_nmi (.clk(clk), .rst_n(RST), .d(NMI), .q(nmi_s));
    sync_ff u_sync_irq (.clk(clk), .rst_n(RST), .d(IRQ), .q(irq_s));
    sync_ff u_sync_so  (.clk(clk), .rst_n(RST), .d(SO),  .q(so_s));

    assign nmi_fall = nmi_d & ~nmi_s;
    assign irq_req  = ~irq_s & ~sr_I;

    // Edge registers, NMI latch and SO pulse. A fresh NMI edge wins over the
    // vec_ack that would otherwise clear the pending flag, so back-to-back
    // NMIs are never dropped.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            nmi_d    <= 1'b1;
            so_d     <= 1'b1;
            so_set   <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            nmi_d  <= nmi_s;
            so_d   <= so_s;
            so_set <= so_d & ~so_s;
            if (nmi_fall)
                nmi_pend <= 1'b1;
            else if (vec_ack && state == NMI_SEQ)
                nmi_pend <= 1'b0;
        end
    end

    // Sequencer. A pending NMI arriving during an IRQ sequence hijacks it
    // so the same stacked frame is vectored through the NMI vector.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= RST_SEQ;
        end else begin
            case (state)
                RST_SEQ: if (vec_ack) state <= IDLE;
                IDLE: begin
                    if (fetch && nmi_pend)
                        state <= NMI_SEQ;
                    else if (fetch && irq_req)
                        state <= IRQ_SEQ;
                end
                NMI_SEQ: if (vec_ack) state <= IDLE;
                IRQ_SEQ: begin
                    if (vec_ack)
                        state <= IDLE;
                    else if (nmi_pend)
                        state <= NMI_SEQ;
                end
                default: state <= RST_SEQ;
            endcase
        end
    end

    // Injection is decided combinationally inside the fetch cycle itself;
    // the state moves at the edge that closes that cycle.
    assign take_req = (state == RST_SEQ) ||
                      ((state == IDLE) && (nmi_pend || irq_req));
    assign int_take = fetch & take_req;
    assign ir_out   = int_take ? OPC_BRK : D_BUS;
    assign vec_lo   = vec_lo_for(state);
    assign brk_flag = (state == IDLE);
    assign seq_rst  = (state == RST_SEQ);

endmodule
